// File: rtl/spi_sram_responder_if.sv
// SPI pin bundle between the SoC master pins and the SRAM responder.
// Ports: SSn/SCLK/MOSI from master; MISO/MISO_OE/frame_done/cmd_err back.
interface spi_sram_responder_if;
  logic SSn;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic MISO_OE;
  logic frame_done;
  logic cmd_err;

  modport master (
    output SSn, SCLK, MOSI,
    input  MISO, MISO_OE, frame_done, cmd_err
  );

  modport slave (
    input  SSn, SCLK, MOSI,
    output MISO, MISO_OE, frame_done, cmd_err
  );
endinterface

// File: rtl/spi_sram_responder.sv
// SPI mode-0 serial SRAM emulator (READ 03 / WRITE 02 / RDSR 05), HCLK oversampled.
// Ports: HCLK, HRESETn (async low), bus (slave modport of spi_sram_responder_if).
module spi_sram_responder #(
  parameter int         AW         = 8,
  parameter logic [7:0] STATUS_VAL = 8'h40
) (
  input  logic HCLK,
  input  logic HRESETn,
  spi_sram_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO,
    S_WR, S_RD, S_STAT, S_IGNORE
  } state_t;

  state_t r_state, w_nxt;

  logic [1:0]    r_ss_sync, r_sck_sync, r_mosi_sync;
  logic          r_ss_d, r_sck_d;
  logic [2:0]    r_bcnt;
  logic [7:0]    r_rx, r_tx;
  logic [AW-1:0] r_addr;
  logic          r_op_wr;
  logic          r_wr_pend;
  logic          r_miso, r_oe, r_frame_done, r_cmd_err;
  logic [7:0]    r_mem [0:(1<<AW)-1];

  logic          w_ss, w_ss_fall, w_rise, w_fall, w_mosi, w_last;
  logic [7:0]    w_rx_byte;
  logic [AW-1:0] w_addr_nxt, w_addr_inc;
  logic          w_cmd_rd, w_cmd_wr, w_cmd_st;

  assign w_ss       = r_ss_sync[1];
  assign w_ss_fall  = ~w_ss & r_ss_d;
  assign w_rise     = r_sck_sync[1] & ~r_sck_d;
  assign w_fall     = ~r_sck_sync[1] & r_sck_d;
  assign w_mosi     = r_mosi_sync[1];
  assign w_last     = (r_bcnt == 3'd7);
  assign w_rx_byte  = {r_rx[6:0], w_mosi};
  assign w_addr_nxt = {r_addr[AW-2:0], w_mosi};
  assign w_addr_inc = r_addr + 1'b1;
  assign w_cmd_rd   = (w_rx_byte == 8'h03);
  assign w_cmd_wr   = (w_rx_byte == 8'h02);
  assign w_cmd_st   = (w_rx_byte == 8'h05);

  assign bus.MISO       = r_miso;
  assign bus.MISO_OE    = r_oe;
  assign bus.frame_done = r_frame_done;
  assign bus.cmd_err    = r_cmd_err;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ss_sync   <= 2'b11;
      r_sck_sync  <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_ss_d      <= 1'b1;
      r_sck_d     <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[0], bus.SSn};
      r_sck_sync  <= {r_sck_sync[0], bus.SCLK};
      r_mosi_sync <= {r_mosi_sync[0], bus.MOSI};
      r_ss_d      <= r_ss_sync[1];
      r_sck_d     <= r_sck_sync[1];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (w_ss) begin
      w_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_ss_fall) w_nxt = S_CMD;
        S_CMD: begin
          if (w_rise && w_last) begin
            unique case (1'b1)
              w_cmd_rd, w_cmd_wr: w_nxt = S_ADDR_HI;
              w_cmd_st:           w_nxt = S_STAT;
              default:            w_nxt = S_IGNORE;
            endcase
          end
        end
        S_ADDR_HI: if (w_rise && w_last) w_nxt = S_ADDR_LO;
        S_ADDR_LO: begin
          if (w_rise && w_last)
            w_nxt = r_op_wr ? S_WR : S_RD;
        end
        default: w_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_bcnt       <= '0;
      r_rx         <= '0;
      r_tx         <= '0;
      r_addr       <= '0;
      r_op_wr      <= 1'b0;
      r_wr_pend    <= 1'b0;
      r_miso       <= 1'b0;
      r_oe         <= 1'b0;
      r_frame_done <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_wr_pend    <= 1'b0;
      // a completed byte commits one cycle after its 8th bit
      if (r_wr_pend) r_addr <= w_addr_inc;
      if (w_ss) begin
        r_bcnt       <= '0;
        r_oe         <= 1'b0;
        r_miso       <= 1'b0;
        r_frame_done <= (r_state != S_IDLE);
      end else begin
        unique case (r_state)
          S_CMD: begin
            if (w_rise) begin
              r_rx   <= w_rx_byte;
              r_bcnt <= r_bcnt + 3'd1;
              if (w_last) begin
                r_op_wr   <= w_cmd_wr;
                r_cmd_err <= ~(w_cmd_rd | w_cmd_wr | w_cmd_st);
                r_tx      <= STATUS_VAL;
              end
            end
          end
          S_ADDR_HI: begin
            if (w_rise) begin
              r_addr <= w_addr_nxt;
              r_bcnt <= r_bcnt + 3'd1;
            end
          end
          S_ADDR_LO: begin
            if (w_rise) begin
              r_addr <= w_addr_nxt;
              r_bcnt <= r_bcnt + 3'd1;
              if (w_last) r_tx <= r_mem[w_addr_nxt];
            end
          end
          S_WR: begin
            if (w_rise) begin
              r_rx   <= w_rx_byte;
              r_bcnt <= r_bcnt + 3'd1;
              if (w_last) r_wr_pend <= 1'b1;
            end
          end
          S_RD, S_STAT: begin
            if (w_fall) begin
              r_oe   <= 1'b1;
              r_miso <= r_tx[7];
              r_bcnt <= r_bcnt + 3'd1;
              if (!w_last) begin
                r_tx <= {r_tx[6:0], 1'b0};
              end else if (r_state == S_RD) begin
                r_addr <= w_addr_inc;
                r_tx   <= r_mem[w_addr_inc];
              end else begin
                r_tx <= STATUS_VAL;
              end
            end
          end
          default: begin
            r_oe   <= 1'b0;
            r_miso <= 1'b0;
          end
        endcase
      end
    end
  end

  // array is intentionally left out of reset
  always_ff @(posedge HCLK) begin
    if (r_wr_pend) r_mem[r_addr] <= r_rx;
  end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Scoreboard bench for spi_sram_responder: SPI master at HCLK/10.
// Drives frames, checks MISO bytes, MISO_OE, frame_done and cmd_err.
module tb_spi_sram_responder;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  spi_sram_responder_if bus();

  spi_sram_responder #(
    .AW(8),
    .STATUS_VAL(8'h40)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .bus(bus)
  );

  logic [7:0] model [256];
  logic [7:0] sb_q [$];
  int n_chk = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  int ce_cnt = 0;

  always @(posedge HCLK) begin
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (bus.cmd_err === 1'b1) ce_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [7:0] got);
    logic [7:0] e;
    chk({tag, "_q"}, 32'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(tag, got, e);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n,
                          output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    rx = 8'h00;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i > 7 - n; i--) begin
      bus.MOSI = tx[i];
      #50;
      bus.SCLK = 1'b1;
      rx[i] = bus.MISO;
      oe_all = oe_all & bus.MISO_OE;
      oe_any = oe_any | bus.MISO_OE;
      #50;
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic frame_begin();
    bus.SSn = 1'b0;
    #60;
  endtask

  task automatic frame_end();
    #60;
    bus.SSn = 1'b1;
    #100;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] a);
    logic [7:0] rx;
    logic oa, o1, o2, o3;
    spi_bits(cmd, 8, rx, oa, o1);
    spi_bits(a[15:8], 8, rx, oa, o2);
    spi_bits(a[7:0], 8, rx, oa, o3);
    chk("hdr_oe", {31'b0, o1 | o2 | o3}, 0);
  endtask

  task automatic wr_frame(input logic [15:0] a, input logic [15:0] d,
                          input int n);
    logic [7:0] rx;
    logic oa, on;
    int fd0;
    fd0 = fd_cnt;
    frame_begin();
    send_hdr(8'h02, a);
    for (int i = 0; i < n; i++) begin
      spi_bits(d[15-8*i -: 8], 8, rx, oa, on);
      model[8'(a + 16'(i))] = d[15-8*i -: 8];
    end
    frame_end();
    chk("wr_fd", fd_cnt, fd0 + 1);
  endtask

  task automatic rd_frame(input logic [15:0] a, input int n);
    logic [7:0] rx;
    logic oa, on;
    int fd0;
    fd0 = fd_cnt;
    frame_begin();
    send_hdr(8'h03, a);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(model[8'(a + 16'(i))]);
      spi_bits(8'h00, 8, rx, oa, on);
      sb_pop("rd_data", rx);
      chk("rd_oe", {31'b0, oa}, 1);
    end
    frame_end();
    chk("rd_fd", fd_cnt, fd0 + 1);
  endtask

  initial begin
    logic [7:0] rx;
    logic oa, on;
    int fd0, ce0;
    bus.SSn = 1'b1;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    #23;
    chk("rst_miso", {31'b0, bus.MISO}, 0);
    chk("rst_oe", {31'b0, bus.MISO_OE}, 0);
    chk("rst_fd", {31'b0, bus.frame_done}, 0);
    chk("rst_ce", {31'b0, bus.cmd_err}, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    #100;

    wr_frame(16'h0010, 16'hA55A, 2);
    rd_frame(16'h0010, 2);

    wr_frame(16'h00FF, 16'h1122, 2);
    rd_frame(16'h00FF, 2);
    rd_frame(16'h0000, 1);

    fd0 = fd_cnt;
    ce0 = ce_cnt;
    frame_begin();
    spi_bits(8'h9F, 8, rx, oa, on);
    chk("bad_oe0", {31'b0, on}, 0);
    spi_bits(8'hFF, 8, rx, oa, on);
    chk("bad_oe1", {31'b0, on}, 0);
    chk("bad_miso1", rx, 0);
    spi_bits(8'h55, 8, rx, oa, on);
    chk("bad_oe2", {31'b0, on}, 0);
    chk("bad_miso2", rx, 0);
    frame_end();
    chk("bad_ce", ce_cnt, ce0 + 1);
    chk("bad_fd", fd_cnt, fd0 + 1);

    wr_frame(16'h0020, 16'h3C00, 1);
    fd0 = fd_cnt;
    frame_begin();
    send_hdr(8'h02, 16'h0020);
    spi_bits(8'hFF, 5, rx, oa, on);
    frame_end();
    chk("part_fd", fd_cnt, fd0 + 1);
    rd_frame(16'h0020, 1);
    rd_frame(16'h0010, 1);

    fd0 = fd_cnt;
    frame_begin();
    spi_bits(8'h05, 8, rx, oa, on);
    chk("st_hdr_oe", {31'b0, on}, 0);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(8'h40);
      spi_bits(8'h00, 8, rx, oa, on);
      sb_pop("st_data", rx);
      chk("st_oe", {31'b0, oa}, 1);
    end
    frame_end();
    chk("st_fd", fd_cnt, fd0 + 1);

    fd0 = fd_cnt;
    frame_begin();
    spi_bits(8'h03, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h10, 3, rx, oa, on);
    HRESETn = 1'b0;
    bus.SSn = 1'b1;
    #1;
    chk("ra_miso", {31'b0, bus.MISO}, 0);
    chk("ra_oe", {31'b0, bus.MISO_OE}, 0);
    chk("ra_fd", {31'b0, bus.frame_done}, 0);
    chk("ra_ce", {31'b0, bus.cmd_err}, 0);
    #49;
    HRESETn = 1'b1;
    #100;
    chk("ra_nofd", fd_cnt, fd0);
    rd_frame(16'h0010, 2);

    frame_begin();
    send_hdr(8'h03, 16'h00FF);
    spi_bits(8'h00, 3, rx, oa, on);
    chk("rdp_oe_pre", {31'b0, oa}, 1);
    HRESETn = 1'b0;
    bus.SSn = 1'b1;
    #1;
    chk("rdp_oe", {31'b0, bus.MISO_OE}, 0);
    chk("rdp_miso", {31'b0, bus.MISO}, 0);
    #49;
    HRESETn = 1'b1;
    #100;
    rd_frame(16'h00FF, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
